pc_redirect_ctrl: RTL and testbench

//  Fetch-PC sequencer for the RV64I core. Presents sequential PCs to fetch and applies redirects.

---
 rtl/rv_core_pkg.sv | 16 +
 rtl/pc_redirect_ctrl_if.sv | 30 +++
 rtl/pc_next_sel.sv | 48 ++++
 rtl/pc_redirect_ctrl.sv | 119 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV64I core definitions: datapath width, default reset vector,
// instruction size and the fetch-PC sequencer state type.
package rv_core_pkg;

    localparam int unsigned XLEN                 = 64;
    localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int unsigned INSN_BYTES           = 4;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        FLUSH     = 2'd2,
        WAIT_TRAP = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-side redirect bus: execute/CSR redirect requests in, fetch PC and
// flush control out. slave = the PC sequencer, master = its environment.
interface pc_redirect_ctrl_if #(
    parameter int unsigned XLEN = rv_core_pkg::XLEN
);

    logic            ex_valid;
    logic            ex_do_jump;
    logic [XLEN-1:0] ex_target;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic            fetch_ready;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid;
    logic            flush;
    logic            ex_ready;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;

    modport slave (
        input  ex_valid, ex_do_jump, ex_target, trap_req, trap_vec, fetch_ready,
        output pc_out, pc_valid, flush, ex_ready, misalign_exc, misalign_addr
    );

    modport master (
        output ex_valid, ex_do_jump, ex_target, trap_req, trap_vec, fetch_ready,
        input  pc_out, pc_valid, flush, ex_ready, misalign_exc, misalign_addr
    );

endinterface

// File: rtl/pc_next_sel.sv
// Next-fetch-PC priority select: trap vector > taken branch/jump > sequential.
// Optional macro MISALIGN_TRAP_EN: a taken target with nonzero low bits is
// reported as misaligned instead of being redirected to.
module pc_next_sel #(
    parameter int unsigned XLEN = rv_core_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance_en,
    input  logic            jump_req,
    input  logic [XLEN-1:0] ex_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect,
    output logic            misalign
);
    import rv_core_pkg::*;

    logic [XLEN-1:0] jump_pc;

    assign jump_pc = {ex_target[XLEN-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign misalign = jump_req & ~trap_req & (ex_target[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^ex_target[1:0];
    assign misalign        = 1'b0;
`endif

    // Priority select; a redirect or misaligned jump discards any handshake
    always_comb begin
        redirect = 1'b0;
        next_pc  = pc;
        if (trap_req) begin
            redirect = 1'b1;
            next_pc  = trap_vec;
        end else if (jump_req) begin
            if (!misalign) begin
                redirect = 1'b1;
                next_pc  = jump_pc;
            end
        end else if (advance_en) begin
            next_pc = pc + XLEN'(INSN_BYTES);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer for the RV64I core: presents sequential PCs to fetch,
// applies execute and trap redirects with a one-cycle F/D flush.
// Optional macro MISALIGN_TRAP_EN: misaligned taken targets raise
// misalign_exc and park the sequencer until the CSR unit redirects.
module pc_redirect_ctrl #(
    parameter int unsigned     XLEN         = rv_core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = rv_core_pkg::RESET_VECTOR_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    pc_redirect_ctrl_if.slave bus
);
    import rv_core_pkg::*;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] sel_pc;
    logic            flush_q, flush_d;
    logic            in_run;
    logic            jump_req;
    logic            trap_ok;
    logic            redirect;
    logic            misalign;

    assign in_run   = (state_q == RUN);
    // Execute results are wrong-path outside RUN; traps are ignored only in BOOT
    assign jump_req = in_run & bus.ex_valid & bus.ex_do_jump;
    assign trap_ok  = bus.trap_req & (state_q != BOOT);

    pc_next_sel #(
        .XLEN (XLEN)
    ) u_next_sel (
        .pc         (pc_q),
        .advance_en (in_run & bus.fetch_ready),
        .jump_req   (jump_req),
        .ex_target  (bus.ex_target),
        .trap_req   (trap_ok),
        .trap_vec   (bus.trap_vec),
        .next_pc    (sel_pc),
        .redirect   (redirect),
        .misalign   (misalign)
    );

    // Next-state and flush pulse decode
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end else if (misalign) begin
                    state_d = WAIT_TRAP;
                    flush_d = 1'b1;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_TRAP: begin
                if (redirect) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State, PC and flush registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= sel_pc;
            flush_q <= flush_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic            mexc_q;
    logic [XLEN-1:0] maddr_q;

    // One-cycle exception pulse; faulting address held until the next fault
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mexc_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            mexc_q <= misalign;
            if (misalign) begin
                maddr_q <= bus.ex_target;
            end
        end
    end

    assign bus.misalign_exc  = mexc_q;
    assign bus.misalign_addr = maddr_q;
`else
    assign bus.misalign_exc  = 1'b0;
    assign bus.misalign_addr = '0;
`endif

    assign bus.pc_out   = pc_q;
    assign bus.pc_valid = in_run;
    assign bus.ex_ready = in_run;
    assign bus.flush    = flush_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl (honours MISALIGN_TRAP_EN if defined).
module tb_pc_redirect_ctrl;

    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;
`ifdef MISALIGN_TRAP_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_redirect_ctrl_if #(.XLEN(64)) bus ();

    pc_redirect_ctrl #(
        .XLEN         (64),
        .RESET_VECTOR (RV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: what fetch should currently see
    logic [63:0] m_pc    = RV;
    logic        m_valid = 1'b0;
    logic        m_boot  = 1'b1;
    logic        m_wait  = 1'b0;
    logic        m_flush = 1'b0;
    logic        m_mexc  = 1'b0;
    logic [63:0] m_maddr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_pc = RV; m_boot = 1'b1; m_valid = 1'b0; m_wait = 1'b0;
            m_flush = 1'b0; m_mexc = 1'b0; m_maddr = '0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b1; m_flush = 1'b0; m_mexc = 1'b0;
        end else if (m_valid) begin
            m_flush = 1'b0; m_mexc = 1'b0;
            if (bus.trap_req) begin
                m_pc = bus.trap_vec; m_valid = 1'b0; m_flush = 1'b1;
            end else if (bus.ex_valid && bus.ex_do_jump) begin
                if (EN && (bus.ex_target % 4) != 0) begin
                    m_wait = 1'b1; m_valid = 1'b0; m_flush = 1'b1;
                    m_mexc = 1'b1; m_maddr = bus.ex_target;
                end else begin
                    m_pc = bus.ex_target - (bus.ex_target % 4);
                    m_valid = 1'b0; m_flush = 1'b1;
                end
            end else if (bus.fetch_ready) begin
                m_pc = m_pc + 64'd4;
            end
        end else begin
            m_mexc = 1'b0;
            if (bus.trap_req) begin
                m_pc = bus.trap_vec; m_flush = 1'b1; m_wait = 1'b0;
            end else if (m_wait) begin
                m_flush = 1'b0;
            end else begin
                m_valid = 1'b1; m_flush = 1'b0;
            end
        end
    endtask

    // Advance one clock and compare every output against the model
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("pc_out", bus.pc_out, m_pc);
        chk("pc_valid", 64'(bus.pc_valid), 64'(m_valid));
        chk("ex_ready", 64'(bus.ex_ready), 64'(m_valid));
        chk("flush", 64'(bus.flush), 64'(m_flush));
        chk("misalign_exc", 64'(bus.misalign_exc), 64'(m_mexc));
        chk("misalign_addr", bus.misalign_addr, m_maddr);
    endtask

    task automatic idle_inputs();
        bus.ex_valid = 1'b0; bus.ex_do_jump = 1'b0; bus.ex_target = '0;
        bus.trap_req = 1'b0; bus.trap_vec = '0;
    endtask

    task automatic jump(input logic [63:0] t);
        bus.ex_valid = 1'b1; bus.ex_do_jump = 1'b1; bus.ex_target = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.fetch_ready = 1'b1;
        #1;
        cycle(); cycle();
        chk("rst_valid", 64'(bus.pc_valid), 64'd0);
        chk("rst_pc", bus.pc_out, RV);

        // Boot and sequential fetch
        rst_n = 1'b1;
        cycle(); chk("seq0", bus.pc_out, 64'h8000_0000); chk("seq0_v", 64'(bus.pc_valid), 64'd1);
        cycle(); chk("seq1", bus.pc_out, 64'h8000_0004);
        cycle(); chk("seq2", bus.pc_out, 64'h8000_0008);
        cycle(); cycle(); chk("seq4", bus.pc_out, 64'h8000_0010);

        // Fetch stall holds the PC
        bus.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("stall_pc", bus.pc_out, 64'h8000_0010); chk("stall_v", 64'(bus.pc_valid), 64'd1);
        end
        bus.fetch_ready = 1'b1;
        cycle(); chk("resume", bus.pc_out, 64'h8000_0014);

        // Taken jump: flush then target, handshake in N discarded
        jump(64'h8000_1000);
        cycle(); chk("j_flush", 64'(bus.flush), 64'd1); chk("j_v", 64'(bus.pc_valid), 64'd0);
        idle_inputs();
        cycle(); chk("j_pc", bus.pc_out, 64'h8000_1000); chk("j_v2", 64'(bus.pc_valid), 64'd1);

        // do_jump without ex_valid, and non-taken resolution: no effect
        bus.ex_do_jump = 1'b1; bus.ex_target = 64'h1234_0000;
        cycle(); chk("nojump", bus.pc_out, 64'h8000_1004);
        bus.ex_do_jump = 1'b0; bus.ex_valid = 1'b1;
        cycle(); chk("nottaken", bus.pc_out, 64'h8000_1008);
        idle_inputs();

        // Trap beats a same-cycle jump
        jump(64'h8000_1000); bus.trap_req = 1'b1; bus.trap_vec = 64'h8000_0100;
        cycle(); idle_inputs();
        cycle(); chk("trap_pri", bus.pc_out, 64'h8000_0100);

        // Execute redirects are ignored during FLUSH
        jump(64'h9000_0000);
        cycle(); jump(64'hA000_0000);
        cycle(); idle_inputs(); chk("flush_ign", bus.pc_out, 64'h9000_0000);

        // Trap during FLUSH extends the flush and replaces the PC
        jump(64'h9000_0040);
        cycle(); idle_inputs(); bus.trap_req = 1'b1; bus.trap_vec = 64'h9000_0200;
        cycle(); idle_inputs(); chk("ftrap_fl", 64'(bus.flush), 64'd1); chk("ftrap_pc", bus.pc_out, 64'h9000_0200);
        cycle(); chk("ftrap_run", bus.pc_out, 64'h9000_0200); chk("ftrap_v", 64'(bus.pc_valid), 64'd1);

        // Misaligned taken target
        jump(64'h8000_1002);
        cycle(); idle_inputs();
        if (EN) begin
            chk("mis_exc", 64'(bus.misalign_exc), 64'd1);
            chk("mis_addr", bus.misalign_addr, 64'h8000_1002);
            cycle(); cycle(); chk("mis_wait", 64'(bus.pc_valid), 64'd0);
            bus.trap_req = 1'b1; bus.trap_vec = 64'h8000_0300;
            cycle(); idle_inputs();
            cycle(); chk("mis_trap", bus.pc_out, 64'h8000_0300);
        end else begin
            cycle(); chk("mis_clr", bus.pc_out, 64'h8000_1000);
        end

        // Trap coincident with a misaligned jump: trap wins
        jump(64'h8000_2003); bus.trap_req = 1'b1; bus.trap_vec = 64'h8000_0400;
        cycle(); idle_inputs(); chk("mtrap_exc", 64'(bus.misalign_exc), 64'd0);
        cycle(); chk("mtrap_pc", bus.pc_out, 64'h8000_0400);

        // PC wraps to zero
        bus.trap_req = 1'b1; bus.trap_vec = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle(); idle_inputs();
        cycle(); chk("wrap_top", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(); chk("wrap_zero", bus.pc_out, 64'h0);

        // Reset in the middle of a flush
        jump(64'h8000_2000);
        cycle(); idle_inputs(); rst_n = 1'b0;
        cycle(); chk("rstf_flush", 64'(bus.flush), 64'd0); chk("rstf_pc", bus.pc_out, RV);
        rst_n = 1'b1;
        cycle(); chk("rstf_run", bus.pc_out, RV); chk("rstf_v", 64'(bus.pc_valid), 64'd1);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
